alu4_sequencer: RTL and testbench

ALU4_SEQUENCER -- requirements
Module: alu4_sequencer

---
 rtl/alu4_sequencer_pkg.sv | 32 +++
 rtl/alu4_sequencer.sv | 100 ++++++++++
 tb/tb_alu4_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu4_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: default width, ALU op
// encodings, FSM state type and the carry/result masking helpers.
package alu4_sequencer_pkg;

  localparam int WIDTH_DEF = 4;

  // Arithmetic encodings (alu_m = 0)
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  // Logic encodings (alu_m = 1)
  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_PASSA = 2'b10;
  localparam logic [1:0] OP_PASSB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Carry/borrow is only meaningful for add and subtract.
  function automatic logic carry_meaningful(input logic m, input logic [1:0] op);
    return (m == 1'b0) && ((op == OP_ADD) || (op == OP_SUB));
  endfunction

  // Arithmetic mode with ops 10/11 has no defined result; it is captured as zero.
  function automatic logic arith_reserved(input logic m, input logic [1:0] op);
    return (m == 1'b0) && ((op == OP_PASSA) || (op == OP_PASSB));
  endfunction

endpackage

// File: rtl/alu4_sequencer.sv
// Command sequencer in front of an external combinational ALU: registers one
// command, waits one EXEC cycle for the ALU, then holds the result until consumed.
module alu4_sequencer
  import alu4_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_m,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_cin,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_zero,
  output logic [7:0]       op_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // cmd_ready is high only in IDLE; res_valid is high only in DONE and the
  // result fields hold steady until res_ready is seen.

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cap_sum;
  logic             cap_cout;

  always_comb begin
    cap_sum  = alu_sum;
    cap_cout = 1'b0;
    if (arith_reserved(alu_m, alu_op)) begin
      cap_sum = '0;
    end
    if (carry_meaningful(alu_m, alu_op)) begin
      cap_cout = alu_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_m    <= 1'b0;
      alu_op   <= 2'b00;
      alu_cin  <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      acc      <= '0;
      op_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_m   <= cmd_m;
            alu_op  <= cmd_op;
            alu_cin <= cmd_cin;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_sum  <= cap_sum;
          res_cout <= cap_cout;
          acc      <= cap_sum;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            op_count <= op_count + 8'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign res_zero  = (res_sum == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu4_sequencer.sv
// Bench for alu4_sequencer paired with a behavioural 4-bit ALU; directed
// commands push expected results that a negedge monitor pops and compares.
module tb_alu4_sequencer;
  import alu4_sequencer_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_m;
  logic [1:0]   cmd_op;
  logic         cmd_cin;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_m;
  logic [1:0]   alu_op;
  logic         alu_cin;
  logic [W-1:0] alu_sum;
  logic         alu_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_zero;
  logic [7:0]   op_count;
  logic [1:0]   dbg_state;

  logic         force_cout;
  logic [W:0]   mdl;
  logic [W+1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  alu4_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_op(cmd_op),
    .cmd_cin(cmd_cin), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_zero(res_zero),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- external ALU model ----------------
  // Reserved arithmetic ops return garbage with carry set so masking is exercised.
  always_comb begin
    mdl = '0;
    case ({alu_m, alu_op})
      3'b000: mdl = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      3'b001: mdl = {1'b0, alu_a} - {1'b0, alu_b} - {{W{1'b0}}, alu_cin};
      3'b010, 3'b011: mdl = {1'b1, alu_a ^ alu_b ^ {W{1'b1}}};
      3'b100: mdl = {1'b0, alu_a & alu_b};
      3'b101: mdl = {1'b0, alu_a | alu_b};
      3'b110: mdl = {1'b0, alu_a};
      3'b111: mdl = {1'b0, alu_b};
      default: mdl = '0;
    endcase
    alu_sum  = mdl[W-1:0];
    alu_cout = mdl[W] | force_cout;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: a result transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {29'd0, res_zero, res_cout, res_sum}, 32'hFFFF_FFFF);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("res_sum",  {28'd0, res_sum},  {28'd0, e[W-1:0]});
        check("res_cout", {31'd0, res_cout}, {31'd0, e[W]});
        check("res_zero", {31'd0, res_zero}, {31'd0, e[W+1]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [1:0] op, input logic cin, input logic use_acc,
                       input logic [W-1:0] es, input logic ec,
                       input bit push, input bit chk_lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_a = a; cmd_b = b; cmd_m = m; cmd_op = op; cmd_cin = cin; cmd_use_acc = use_acc;
    cmd_valid = 1'b1;
    if (push) exp_q.push_back({(es == '0), ec, es});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = W'($urandom_range(0, 15));
    cmd_b = W'($urandom_range(0, 15));
    if (chk_lat) begin
      @(negedge clk);
      check("lat_exec_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check("lat_done_valid", {31'd0, res_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   s;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1; force_cout = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_m = 1'b0; cmd_op = 2'b00; cmd_cin = 1'b0; cmd_use_acc = 1'b0;
    #23;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_sum",   {28'd0, res_sum},   32'd0);
    check("rst_res_cout",  {31'd0, res_cout},  32'd0);
    check("rst_res_zero",  {31'd0, res_zero},  32'd1);
    check("rst_op_count",  {24'd0, op_count},  32'd0);
    check("rst_alu_ctl",   {21'd0, alu_a, alu_b, alu_m, alu_op, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Add 9+8+1 = 18 -> sum 2, carry 1, with latency check
    issue(4'd9, 4'd8, 1'b0, OP_ADD, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1, 1'b1);
    // Subtract with borrow, then equal operands
    issue(4'd3, 4'd5, 1'b0, OP_SUB, 1'b0, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0);
    issue(4'd5, 4'd5, 1'b0, OP_SUB, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drain();
    // Logic ops with the ALU carry forced high: carry must be masked
    force_cout = 1'b1;
    issue(4'hC, 4'hA, 1'b1, OP_AND,   1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    issue(4'hC, 4'h3, 1'b1, OP_OR,    1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
    issue(4'h6, 4'h9, 1'b1, OP_PASSA, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
    issue(4'h6, 4'h9, 1'b1, OP_PASSB, 1'b0, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0);
    force_cout = 1'b0;
    // Reserved arithmetic op: result and carry forced to zero
    issue(4'h3, 4'h5, 1'b0, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    issue(4'h7, 4'h1, 1'b0, 2'b11, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drain();
    check("op_count_after_9", {24'd0, op_count}, 32'd9);

    // Backpressure: 7+1 held, commands during DONE ignored
    res_ready = 1'b0;
    issue(4'd7, 4'd1, 1'b0, OP_ADD, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_sum",   {28'd0, res_sum},   32'd8);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_alu_ab",    {24'd0, alu_a, alu_b}, 32'h71);
      cmd_valid = 1'b1;
      cmd_a = W'($urandom_range(0, 15));
      cmd_b = W'($urandom_range(0, 15));
      cmd_op = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain();
    check("op_count_after_bp", {24'd0, op_count}, 32'd10);
    // Accumulator chain: acc(8) + 2 = A
    issue(4'h3, 4'd2, 1'b0, OP_ADD, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    check("chain_alu_a", {28'd0, alu_a}, 32'd8);
    drain();

    // Reset during EXEC abandons the operation
    issue(4'd3, 4'd4, 1'b0, OP_ADD, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_op_count",  {24'd0, op_count},  32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_res_valid", {31'd0, res_valid}, 32'd0);
    // Accumulator must be zero: acc + 3 = 3
    issue(4'h9, 4'd3, 1'b0, OP_ADD, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    drain();
    check("postrst_op_count", {24'd0, op_count}, 32'd1);

    // 255 more completed ops wrap the counter back to zero
    for (int i = 0; i < 255; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      issue(ra, rb, 1'b0, OP_ADD, rc, 1'b0, s[W-1:0], s[W], 1'b1, 1'b0);
    end
    drain();
    check("op_count_wrap", {24'd0, op_count}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
